isa_bus_arbiter: RTL

Shares the single ISA bus cycle engine between two requesters: the HPS host register port (requester 0) and the DSP DMA channel (requester 1). Uses round-robin arbitration and latches the winner's address, direction and write data. It holds the engine's read or write command until the engine reports completion, then returns read data and a one-cycle acknowledge to the owner. A watchdog aborts cycles the engine never completes.

---
 rtl/isa_bus_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/isa_bus_arbiter.sv
// isa_bus_arbiter: shares one ISA bus cycle engine between the HPS
// host port (req0) and the DSP DMA channel (req1), round-robin.
//
// Ports:
//   clk, reset (sync, active-low)
//   req0/1, we0/1, addr0/1, wdata0/1 : requester side
//   ack0/1, rdata, err               : completion back to the owner
//   eng_rd/wr, eng_addr, eng_wdata   : command to the cycle engine
//   eng_rdata, eng_done              : engine response
//   busy, state_debug                : status
module isa_bus_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              eng_rd,
    output logic              eng_wr,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [7:0]        eng_wdata,
    input  logic [7:0]        eng_rdata,
    input  logic              eng_done,
    output logic              busy,
    output logic [2:0]        state_debug
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_COOL  = 3'd4;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              gnt;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        // On a tie the requester that did not win last time goes next.
        gnt     = (req0 & req1) ? ~last_q : req1;

        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    owner_d = gnt;
                    we_d    = gnt ? we1 : we0;
                    addr_d  = gnt ? addr1 : addr0;
                    wdata_d = gnt ? wdata1 : wdata0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                wr_d    = we_q;
                rd_d    = ~we_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Completion takes priority over a coincident timeout.
                if (eng_done) begin
                    rdata_d = we_q ? 8'h00 : eng_rdata;
                    err_d   = 1'b0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                state_d = S_COOL;
            end
            S_COOL: begin
                state_d = S_IDLE;
            end
            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign eng_rd      = rd_q;
    assign eng_wr      = wr_q;
    assign eng_addr    = addr_q;
    assign eng_wdata   = wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign state_debug = state_q;

endmodule
